// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for a classic 5-stage in-order pipeline.
// Resolves load-use hazards by inserting bubbles, squashes wrong-path
// instructions after a taken branch, and freezes the whole pipe while the
// data memory is busy. Stall and flush events are counted with saturating
// 16-bit counters. Control outputs are combinational from state and inputs
// so the stage registers see them in the same cycle the hazard appears.
module pipe_hazard_ctrl #(
  parameter int LOAD_BUBBLES   = 1,
  parameter int BRANCH_PENALTY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        branch_taken,
  input  logic        mem_busy,
  input  logic        cnt_clr,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_hazard,
  output logic        pipe_freeze,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BUBBLE = 2'd1,
    FLUSH  = 2'd2,
    FREEZE = 2'd3
  } state_t;

  // Cycles still owed after the first bubble / flush cycle has been issued.
  localparam logic [3:0] LOAD_REM   = 4'(LOAD_BUBBLES - 1);
  localparam logic [3:0] BRANCH_REM = 4'(BRANCH_PENALTY - 1);
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;

  state_t      state_r;
  state_t      resume_r;     // state to return to when a freeze ends
  state_t      state_nxt_s;
  state_t      resume_nxt_s;
  state_t      eff_s;        // state whose rules apply this cycle
  logic [3:0]  rem_r;
  logic [3:0]  rem_nxt_s;
  logic        load_use_s;
  logic        flush_evt_s;
  logic [15:0] stall_cnt_r;
  logic [15:0] flush_cnt_r;

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

  // Load-use detection: a load in EX writes a register the ID instruction reads.
  always_comb begin
    load_use_s = 1'b0;
    if (ex_memread && (ex_rt != 5'd0)) begin
      if ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt))) begin
        load_use_s = 1'b1;
      end else begin
        load_use_s = 1'b0;
      end
    end else begin
      load_use_s = 1'b0;
    end
  end

  // Next-state, remaining-cycle and pipeline control decode.
  always_comb begin
    // A freeze is transparent: once memory is ready the interrupted state resumes
    // in the same cycle, so the rules of the remembered state are evaluated.
    if (state_r == FREEZE) begin
      eff_s = resume_r;
    end else begin
      eff_s = state_r;
    end

    state_nxt_s  = state_r;
    resume_nxt_s = resume_r;
    rem_nxt_s    = rem_r;
    flush_evt_s  = 1'b0;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_hazard = 1'b0;
    pipe_freeze  = 1'b0;

    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_hazard = 1'b1;
      pipe_freeze  = 1'b0;
      state_nxt_s  = RUN;
      resume_nxt_s = RUN;
      rem_nxt_s    = 4'd0;
    end else if (mem_busy) begin
      // Everything holds; rem is untouched so the sequence resumes exactly.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_hazard = 1'b0;
      pipe_freeze  = 1'b1;
      state_nxt_s  = FREEZE;
      resume_nxt_s = eff_s;
    end else begin
      case (eff_s)
        FLUSH: begin
          // Branch resolution in FLUSH is ignored: those are wrong-path instructions.
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_hazard = 1'b1;
          if (rem_r <= 4'd1) begin
            state_nxt_s = RUN;
            rem_nxt_s   = 4'd0;
          end else begin
            state_nxt_s = FLUSH;
            rem_nxt_s   = rem_r - 4'd1;
          end
        end
        RUN, BUBBLE: begin
          if (branch_taken) begin
            // A taken branch outranks a load-use hazard and cancels pending bubbles.
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_hazard = 1'b1;
            flush_evt_s  = 1'b1;
            if (BRANCH_REM == 4'd0) begin
              state_nxt_s = RUN;
              rem_nxt_s   = 4'd0;
            end else begin
              state_nxt_s = FLUSH;
              rem_nxt_s   = BRANCH_REM;
            end
          end else if (eff_s == BUBBLE) begin
            // Already bubbling: load_use is not re-evaluated, just count down.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_hazard = 1'b1;
            if (rem_r <= 4'd1) begin
              state_nxt_s = RUN;
              rem_nxt_s   = 4'd0;
            end else begin
              state_nxt_s = BUBBLE;
              rem_nxt_s   = rem_r - 4'd1;
            end
          end else if (load_use_s) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_hazard = 1'b1;
            if (LOAD_REM == 4'd0) begin
              state_nxt_s = RUN;
              rem_nxt_s   = 4'd0;
            end else begin
              state_nxt_s = BUBBLE;
              rem_nxt_s   = LOAD_REM;
            end
          end else begin
            state_nxt_s = RUN;
            rem_nxt_s   = rem_r;
          end
        end
        default: begin
          // resume_r never holds FREEZE; recover to RUN if it ever did.
          state_nxt_s  = RUN;
          resume_nxt_s = RUN;
          rem_nxt_s    = 4'd0;
        end
      endcase
    end
  end

  // State, resume-state and remaining-cycle registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= RUN;
      resume_r <= RUN;
      rem_r    <= 4'd0;
    end else begin
      state_r  <= state_nxt_s;
      resume_r <= resume_nxt_s;
      rem_r    <= rem_nxt_s;
    end
  end

  // Saturating event counters; a clear wins over a same-edge increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= 16'd0;
      flush_cnt_r <= 16'd0;
    end else if (cnt_clr) begin
      stall_cnt_r <= 16'd0;
      flush_cnt_r <= 16'd0;
    end else begin
      if (!pc_write && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + 16'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_evt_s && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + 16'd1;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (default parameters and
// LOAD_BUBBLES=4 / BRANCH_PENALTY=3) share one stimulus stream and are compared
// against a model that tracks only "bubbles owed" and "flushes owed".
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_memread, branch_taken, mem_busy, cnt_clr;

  // Output bundle order: {pc_write, if_id_write, if_id_flush, id_ex_hazard, pipe_freeze}
  wire [4:0]  out_a, out_b;
  wire [15:0] stall_a, flush_a, stall_b, flush_b;

  localparam logic [4:0] O_RST  = 5'b00110;
  localparam logic [4:0] O_FRZ  = 5'b00001;
  localparam logic [4:0] O_FLS  = 5'b11110;
  localparam logic [4:0] O_BUB  = 5'b00010;
  localparam logic [4:0] O_RUN  = 5'b11000;

  pipe_hazard_ctrl dut_a (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .cnt_clr(cnt_clr),
    .pc_write(out_a[4]), .if_id_write(out_a[3]), .if_id_flush(out_a[2]),
    .id_ex_hazard(out_a[1]), .pipe_freeze(out_a[0]),
    .stall_cnt(stall_a), .flush_cnt(flush_a)
  );

  pipe_hazard_ctrl #(.LOAD_BUBBLES(4), .BRANCH_PENALTY(3)) dut_b (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .cnt_clr(cnt_clr),
    .pc_write(out_b[4]), .if_id_write(out_b[3]), .if_id_flush(out_b[2]),
    .id_ex_hazard(out_b[1]), .pipe_freeze(out_b[0]),
    .stall_cnt(stall_b), .flush_cnt(flush_b)
  );

  int comps = 0;
  int errs  = 0;

  // Reference model: per instance, how many bubble / flush cycles are still owed.
  int lb[2] = '{1, 4};
  int bp[2] = '{1, 3};
  int bub_left[2];
  int flush_left[2];
  int m_stall[2];
  int m_flush[2];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    comps++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_load_use();
    return ex_memread && (ex_rt != 5'd0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

  function automatic logic [4:0] m_out(input int i);
    if (rst)                                  return O_RST;
    if (mem_busy)                             return O_FRZ;
    if (flush_left[i] > 0 || branch_taken)    return O_FLS;
    if (bub_left[i] > 0 || m_load_use())      return O_BUB;
    return O_RUN;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      bub_left[i] = 0; flush_left[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
    end
  endtask

  // Model behaviour at a rising clock edge.
  task automatic m_edge();
    for (int i = 0; i < 2; i++) begin
      logic [4:0] o;
      o = m_out(i);
      if (rst) begin
        bub_left[i] = 0; flush_left[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
      end else begin
        if (mem_busy) begin
        end else if (flush_left[i] > 0) begin
          flush_left[i]--;
        end else if (branch_taken) begin
          flush_left[i] = bp[i] - 1;
          bub_left[i]   = 0;
          if (m_flush[i] < 65535) m_flush[i]++;
        end else if (bub_left[i] > 0) begin
          bub_left[i]--;
        end else if (m_load_use()) begin
          bub_left[i] = lb[i] - 1;
        end
        if (cnt_clr) begin
          m_stall[i] = 0; m_flush[i] = 0;
        end else if (o[4] == 1'b0 && m_stall[i] < 65535) begin
          m_stall[i]++;
        end
      end
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic mr, input logic [4:0] ert, input logic br,
                       input logic mb, input logic clr);
    id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_memread = mr; ex_rt = ert;
    branch_taken = br; mem_busy = mb; cnt_clr = clr;
  endtask

  task automatic idle_in();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // One clock cycle, entered and left just after a falling edge.
  task automatic step(input bit chk);
    #1;
    if (chk) begin
      check_val("out_a", 32'(out_a), 32'(m_out(0)));
      check_val("out_b", 32'(out_b), 32'(m_out(1)));
    end
    @(posedge clk);
    m_edge();
    #1;
    if (chk) begin
      check_val("stall_a", 32'(stall_a), 32'(m_stall[0]));
      check_val("flush_a", 32'(flush_a), 32'(m_flush[0]));
      check_val("stall_b", 32'(stall_b), 32'(m_stall[1]));
      check_val("flush_b", 32'(flush_b), 32'(m_flush[1]));
    end
    @(negedge clk);
  endtask

  task automatic idle_steps(input int n);
    for (int k = 0; k < n; k++) begin
      idle_in();
      step(1'b1);
    end
  endtask

  int n_flush, n_frz;

  initial begin
    rst = 1'b1;
    idle_in();
    model_reset();
    @(negedge clk);
    // Reset state, with otherwise hazardous inputs present.
    drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    #1;
    check_val("rst_out_a", 32'(out_a), 32'(O_RST));
    check_val("rst_stall_a", 32'(stall_a), 32'd0);
    step(1'b1);
    rst = 1'b0;
    idle_steps(2);

    // Single load-use bubble with default parameters.
    drive(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1);
    drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    #1;
    check_val("lu_out_a", 32'(out_a), 32'(O_BUB));
    step(1'b1);
    check_val("lu_stall_a", 32'(stall_a), 32'd1);
    idle_in();
    #1;
    check_val("lu_after_a", 32'(out_a), 32'(O_RUN));
    step(1'b1);
    idle_steps(4);

    // Register zero never creates a hazard.
    drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check_val("zero_out_a", 32'(out_a), 32'(O_RUN));
    check_val("zero_out_b", 32'(out_b), 32'(O_RUN));
    step(1'b1);

    // Branch and load-use in the same cycle: the branch wins.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1);
    drive(5'd0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    #1;
    check_val("coll_out_a", 32'(out_a), 32'(O_FLS));
    step(1'b1);
    check_val("coll_flush_a", 32'(flush_a), 32'd1);
    check_val("coll_stall_a", 32'(stall_a), 32'd0);
    idle_steps(3);

    // Freeze in the middle of a 3-cycle flush on dut_b.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1);
    n_flush = 0; n_frz = 0;
    for (int k = 0; k < 7; k++) begin
      idle_in();
      if (k == 0) branch_taken = 1'b1;
      if (k == 2 || k == 3) mem_busy = 1'b1;
      #1;
      if (out_b == O_FLS) n_flush++;
      if (out_b[0]) n_frz++;
      step(1'b1);
    end
    check_val("frz_nflush_b", 32'(n_flush), 32'd3);
    check_val("frz_nfreeze_b", 32'(n_frz), 32'd2);
    check_val("frz_stall_b", 32'(stall_b), 32'd2);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 49) == 0));
      rst = ($urandom_range(0, 149) == 0);
      step(1'b1);
    end
    rst = 1'b0;
    idle_steps(6);

    // Asynchronous reset in the middle of a 4-cycle bubble on dut_b.
    drive(5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    step(1'b1);
    idle_in();
    #1;
    check_val("ar_bub_b", 32'(out_b), 32'(O_BUB));
    #1;
    rst = 1'b1;
    #1;
    check_val("ar_rst_out_a", 32'(out_a), 32'(O_RST));
    check_val("ar_rst_out_b", 32'(out_b), 32'(O_RST));
    check_val("ar_rst_stall_b", 32'(stall_b), 32'd0);
    model_reset();
    #1;
    rst = 1'b0;
    #0.5;
    check_val("ar_rel_out_b", 32'(out_b), 32'(O_RUN));
    @(posedge clk);
    m_edge();
    @(negedge clk);
    idle_steps(2);

    // Saturation of stall_cnt, then clear while stalling.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 65534; k++) step(1'b0);
    check_val("sat_fffe_a", 32'(stall_a), 32'h0000_FFFE);
    for (int k = 0; k < 3; k++) step(1'b1);
    check_val("sat_ffff_a", 32'(stall_a), 32'h0000_FFFF);
    check_val("sat_ffff_b", 32'(stall_b), 32'h0000_FFFF);
    cnt_clr = 1'b1;
    step(1'b1);
    check_val("sat_clr_a", 32'(stall_a), 32'd0);
    idle_steps(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, errs);
    $finish;
  end

endmodule
